// File: rtl/fpu_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// fpu_addsub_pipe_if
// Bundle of the add/sub unit's issue-side and writeback-side signals.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once raised, valid and its payload stay stable until that
// transfer. Ready may depend combinationally on the other side's ready, but
// never on its own side's valid.
//
// Signals (all driven by the master unless noted):
//   inValid, sub, fpuIn1, fpuIn2, inTag    operation request
//   inReady                  (slave)       unit can accept this cycle
//   outReady                               consumer accepts the result
//   outValid, fpuOut, outTag (slave)       result, its tag
//   condCodes                (slave)       {Z, C, N, V}
//   opStatusFlags            (slave)       {NV, OF, UF, NX}
// ---------------------------------------------------------------------------
interface fpu_addsub_pipe_if #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10,
  parameter int TAGW  = 4
);
  localparam int W = 1 + EXPW + FRACW;

  logic            inValid;
  logic            inReady;
  logic            sub;
  logic [W-1:0]    fpuIn1;
  logic [W-1:0]    fpuIn2;
  logic [TAGW-1:0] inTag;
  logic            outValid;
  logic            outReady;
  logic [W-1:0]    fpuOut;
  logic [TAGW-1:0] outTag;
  logic [3:0]      condCodes;
  logic [3:0]      opStatusFlags;

  modport master (
    output inValid, sub, fpuIn1, fpuIn2, inTag, outReady,
    input  inReady, outValid, fpuOut, outTag, condCodes, opStatusFlags
  );

  modport slave (
    input  inValid, sub, fpuIn1, fpuIn2, inTag, outReady,
    output inReady, outValid, fpuOut, outTag, condCodes, opStatusFlags
  );
endinterface

// File: rtl/fpu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fpu_addsub_pipe
// Three-stage pipelined IEEE-style add/subtract, round to nearest even.
//   S1: unpack, effective sign, magnitude sort, special-case detect
//   S2: align smaller significand (guard/round/sticky), add or subtract
//   S3: leading-zero count, normalise, round, pack, flags (drives outputs)
// One op per cycle, 3-cycle latency, 3 ops of capacity, results in order.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high; discards everything in flight
//   bus    fpu_addsub_pipe_if.slave (request, result, condCodes {Z,C,N,V},
//          opStatusFlags {NV,OF,UF,NX}, opaque tag carried alongside)
//
// Build option: define FPU_ADDSUB_FTZ_EN for flush-to-zero (subnormal inputs
// read as signed zero, tiny results flush to signed zero with UF and NX).
// ---------------------------------------------------------------------------
module fpu_addsub_pipe #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10,
  parameter int BIAS  = 2**(EXPW-1)-1,
  parameter int TAGW  = 4
) (
  input logic              clock,
  input logic              reset,
  fpu_addsub_pipe_if.slave bus
);
  localparam int W    = 1 + EXPW + FRACW;
  localparam int AW   = FRACW + 4;          // hidden + frac + G/R/S
  localparam int SW   = FRACW + 5;          // AW plus carry
  localparam int EMAX = 2**EXPW - 1;
  localparam logic [EXPW-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]    QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};
  // Both operands share the bias, so it never enters the datapath; an
  // illegal configuration simply never raises inReady.
  localparam bit PARAMS_OK = (EXPW >= 3) && (FRACW >= 2) && (BIAS > 0);

  // ---------------- pipeline control ----------------
  logic s1Valid, s2Valid, s3Valid;
  logic s1Load, s2Load, s3Load;
  logic rdyEn;
  logic inReady, inFire;

  assign s3Load  = ~s3Valid | bus.outReady;
  assign s2Load  = ~s2Valid | s3Load;
  assign s1Load  = ~s1Valid | s2Load;
  assign inReady = rdyEn & s1Load;
  assign inFire  = bus.inValid & inReady;

  assign bus.inReady = inReady;

  // inReady stays low until the first clock edge after reset releases.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdyEn <= 1'b0;
    else       rdyEn <= PARAMS_OK;
  end

  // ---------------- S1: unpack / sort / specials ----------------
  logic            aSign, bSign, aNan, bNan, aInf, bInf, aSnan, bSnan;
  logic [EXPW-1:0] aExp, bExp, aEff, bEff;
  logic [FRACW-1:0] aFrac, bFrac;
  logic [FRACW:0]  aMant, bMant;
  logic            aBigger;
  logic            nSpecial, nNv;
  logic [W-1:0]    nSpecialVal;

  always_comb begin
    aSign = bus.fpuIn1[W-1];
    aExp  = bus.fpuIn1[W-2:FRACW];
    aFrac = bus.fpuIn1[FRACW-1:0];
    bSign = bus.fpuIn2[W-1] ^ bus.sub;      // subtraction flips operand 2
    bExp  = bus.fpuIn2[W-2:FRACW];
    bFrac = bus.fpuIn2[FRACW-1:0];

    aNan  = (aExp == EXP_ONES) && (aFrac != '0);
    bNan  = (bExp == EXP_ONES) && (bFrac != '0);
    aInf  = (aExp == EXP_ONES) && (aFrac == '0);
    bInf  = (bExp == EXP_ONES) && (bFrac == '0);
    aSnan = aNan & ~aFrac[FRACW-1];
    bSnan = bNan & ~bFrac[FRACW-1];

`ifdef FPU_ADDSUB_FTZ_EN
    aMant = (aExp == '0) ? '0 : {1'b1, aFrac};
    bMant = (bExp == '0) ? '0 : {1'b1, bFrac};
`else
    aMant = {(aExp != '0), aFrac};
    bMant = {(bExp != '0), bFrac};
`endif
    // Subnormals sit at the same scale as exponent 1.
    aEff = (aExp == '0) ? EXPW'(1) : aExp;
    bEff = (bExp == '0) ? EXPW'(1) : bExp;
    aBigger = {aEff, aMant} >= {bEff, bMant};

    nSpecial    = 1'b0;
    nNv         = 1'b0;
    nSpecialVal = QNAN;
    if (aNan || bNan || (aInf && bInf && (aSign != bSign))) begin
      nSpecial    = 1'b1;
      nNv         = aSnan | bSnan | (aInf & bInf);
      nSpecialVal = QNAN;
    end else if (aInf) begin
      nSpecial    = 1'b1;
      nSpecialVal = {aSign, EXP_ONES, {FRACW{1'b0}}};
    end else if (bInf) begin
      nSpecial    = 1'b1;
      nSpecialVal = {bSign, EXP_ONES, {FRACW{1'b0}}};
    end
  end

  logic [TAGW-1:0] s1Tag;
  logic            s1Special, s1Nv, s1SignL, s1EffSub;
  logic [W-1:0]    s1SpecialVal;
  logic [EXPW-1:0] s1ExpL, s1Shift;
  logic [FRACW:0]  s1MantL, s1MantS;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid      <= 1'b0;
      s1Tag        <= '0;
      s1Special    <= 1'b0;
      s1Nv         <= 1'b0;
      s1SpecialVal <= '0;
      s1SignL      <= 1'b0;
      s1EffSub     <= 1'b0;
      s1ExpL       <= '0;
      s1Shift      <= '0;
      s1MantL      <= '0;
      s1MantS      <= '0;
    end else begin
      if (s1Load) s1Valid <= inFire;
      if (inFire) begin
        s1Tag        <= bus.inTag;
        s1Special    <= nSpecial;
        s1Nv         <= nNv;
        s1SpecialVal <= nSpecialVal;
        s1SignL      <= aBigger ? aSign : bSign;
        s1EffSub     <= aSign ^ bSign;
        s1ExpL       <= aBigger ? aEff : bEff;
        s1Shift      <= aBigger ? (aEff - bEff) : (bEff - aEff);
        s1MantL      <= aBigger ? aMant : bMant;
        s1MantS      <= aBigger ? bMant : aMant;
      end
    end
  end

  // ---------------- S2: align + add/sub ----------------
  int               shAmt;
  logic [2*AW-1:0]  alignWide;
  logic [AW-1:0]    alignedS;
  logic [SW-1:0]    sumNext;

  always_comb begin
    shAmt = (int'(s1Shift) > AW-1) ? AW-1 : int'(s1Shift);
    // Lower half catches every bit shifted past sticky; it folds into bit 0.
    alignWide = {s1MantS, 3'b000, {AW{1'b0}}} >> shAmt;
    alignedS  = alignWide[2*AW-1:AW] | {{(AW-1){1'b0}}, |alignWide[AW-1:0]};
    if (s1EffSub) sumNext = {1'b0, s1MantL, 3'b000} - {1'b0, alignedS};
    else          sumNext = {1'b0, s1MantL, 3'b000} + {1'b0, alignedS};
  end

  logic [TAGW-1:0] s2Tag;
  logic            s2Special, s2Nv, s2Sign, s2EffSub;
  logic [W-1:0]    s2SpecialVal;
  logic [EXPW-1:0] s2ExpL;
  logic [SW-1:0]   s2Sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2Valid      <= 1'b0;
      s2Tag        <= '0;
      s2Special    <= 1'b0;
      s2Nv         <= 1'b0;
      s2SpecialVal <= '0;
      s2Sign       <= 1'b0;
      s2EffSub     <= 1'b0;
      s2ExpL       <= '0;
      s2Sum        <= '0;
    end else begin
      if (s2Load) s2Valid <= s1Valid;
      if (s2Load && s1Valid) begin
        s2Tag        <= s1Tag;
        s2Special    <= s1Special;
        s2Nv         <= s1Nv;
        s2SpecialVal <= s1SpecialVal;
        s2Sign       <= s1SignL;
        s2EffSub     <= s1EffSub;
        s2ExpL       <= s1ExpL;
        s2Sum        <= sumNext;
      end
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  int                    lzc, sh, expPre;
  logic [AW-1:0]         norm;
  logic                  guardBit, restBits, inexact, roundUp;
  logic [EXPW+FRACW:0]   magRounded;
  logic [EXPW:0]         expRound;
  logic [W-1:0]          nOut;
  logic [3:0]            nFlags, nCc;
`ifdef FPU_ADDSUB_FTZ_EN
  logic                  tinyPre;
`endif

  always_comb begin
    lzc = AW;
    for (int i = 0; i < AW; i++) begin
      if (s2Sum[i]) lzc = AW - 1 - i;
    end
    sh = 0;
`ifdef FPU_ADDSUB_FTZ_EN
    tinyPre = 1'b0;
`endif
    if (s2Sum[SW-1]) begin
      // Carry out: one step right, keep the dropped bit in sticky.
      norm   = {s2Sum[SW-1:2], s2Sum[1] | s2Sum[0]};
      expPre = int'(s2ExpL) + 1;
    end else begin
`ifdef FPU_ADDSUB_FTZ_EN
      sh      = lzc;
      tinyPre = (lzc >= int'(s2ExpL));
`else
      // Never normalise below exponent 1; what remains is a subnormal.
      sh = (lzc > int'(s2ExpL) - 1) ? int'(s2ExpL) - 1 : lzc;
`endif
      norm   = s2Sum[AW-1:0] << sh;
      expPre = norm[AW-1] ? int'(s2ExpL) - sh : 0;
`ifdef FPU_ADDSUB_FTZ_EN
      if (tinyPre) expPre = 0;
`endif
    end

    guardBit = norm[2];
    restBits = norm[1] | norm[0];
    inexact  = guardBit | restBits;
    roundUp  = guardBit & (restBits | norm[3]);
    // Incrementing {exp, frac} as one integer carries a rounded-up fraction
    // into the exponent (subnormal->normal, max finite->Inf) for free.
    magRounded = {(EXPW+1)'(expPre), norm[AW-2:3]} + {{(EXPW+FRACW){1'b0}}, roundUp};
    expRound   = magRounded[EXPW+FRACW:FRACW];

    nOut   = '0;
    nFlags = '0;
    if (s2Special) begin
      nOut   = s2SpecialVal;
      nFlags = {s2Nv, 3'b000};
    end else if (s2Sum == '0) begin
      // Exact zero: -0 only when both addends were -0.
      nOut = {s2EffSub ? 1'b0 : s2Sign, {(W-1){1'b0}}};
    end else if (expRound >= (EXPW+1)'(EMAX)) begin
      nOut   = {s2Sign, EXP_ONES, {FRACW{1'b0}}};
      nFlags = 4'b0101;
`ifdef FPU_ADDSUB_FTZ_EN
    end else if (tinyPre || (expRound == '0)) begin
      nOut   = {s2Sign, {(W-1){1'b0}}};
      nFlags = 4'b0011;
`endif
    end else begin
      nOut   = {s2Sign, magRounded[EXPW+FRACW-1:0]};
      nFlags = {2'b00, (expRound == '0) & inexact, inexact};
    end
    nCc = {(nOut[W-2:0] == '0), 1'b0, nOut[W-1], nFlags[2]};
  end

  logic [TAGW-1:0] s3Tag;
  logic [W-1:0]    s3Out;
  logic [3:0]      s3Flags, s3Cc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s3Valid <= 1'b0;
      s3Tag   <= '0;
      s3Out   <= '0;
      s3Flags <= '0;
      s3Cc    <= '0;
    end else begin
      if (s3Load) s3Valid <= s2Valid;
      if (s3Load && s2Valid) begin
        s3Tag   <= s2Tag;
        s3Out   <= nOut;
        s3Flags <= nFlags;
        s3Cc    <= nCc;
      end
    end
  end

  assign bus.outValid      = s3Valid;
  assign bus.fpuOut        = s3Out;
  assign bus.outTag        = s3Tag;
  assign bus.condCodes     = s3Cc;
  assign bus.opStatusFlags = s3Flags;
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
`timescale 1ns/1ps
module tb_fpu_addsub_pipe;
  localparam int EXPW  = 5;
  localparam int FRACW = 10;
  localparam int TAGW  = 4;
  localparam int W     = 1 + EXPW + FRACW;
  localparam int EW    = TAGW + W + 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_lat = 1'b1;

  logic [EW-1:0] exp_q[$];
  int            iss_q[$];

  fpu_addsub_pipe_if #(.EXPW(EXPW), .FRACW(FRACW), .TAGW(TAGW)) bus();

  fpu_addsub_pipe #(.EXPW(EXPW), .FRACW(FRACW), .TAGW(TAGW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TAGW-1:0] tg);
    bus.inValid = 1'b1;
    bus.sub     = sb;
    bus.fpuIn1  = a;
    bus.fpuIn2  = b;
    bus.inTag   = tg;
  endtask

  task automatic push_exp(input logic [TAGW-1:0] tg, input logic [W-1:0] eo,
                          input logic [3:0] ecc, input logic [3:0] efl);
    exp_q.push_back({tg, eo, ecc, efl});
    iss_q.push_back(cyc);
  endtask

  // Issue one op; waits (bounded) for inReady, returns just after the
  // accepting edge with inValid dropped.
  task automatic send(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TAGW-1:0] tg, input logic [W-1:0] eo,
                      input logic [3:0] ecc, input logic [3:0] efl);
    int guard_c = 0;
    @(negedge clock);
    drive(sb, a, b, tg);
    while (!bus.inReady && guard_c < 50) begin
      @(negedge clock);
      guard_c++;
    end
    n_checks++;
    if (!bus.inReady) begin
      n_fail++;
      $display("FAIL accept_timeout tag=%0d inReady=%b expected=1", tg, bus.inReady);
    end else begin
      push_exp(tg, eo, ecc, efl);
    end
    @(posedge clock);
    #1 bus.inValid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard_c = 0;
    while (exp_q.size() != 0 && guard_c < 100) begin
      @(posedge clock);
      guard_c++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin : monitor
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    int            iss;
    if (!reset && bus.outValid && bus.outReady) begin
      got = {bus.outTag, bus.fpuOut, bus.condCodes, bus.opStatusFlags};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%h expected=none", got);
      end else begin
        want = exp_q.pop_front();
        iss  = iss_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL result tag=%0d got={tag,out,cc,fl}=%h expected=%h",
                   want[EW-1 -: TAGW], got, want);
        end
        if (chk_lat) begin
          n_checks++;
          if (cyc - iss != 3) begin
            n_fail++;
            $display("FAIL latency tag=%0d got=%0d expected=3", want[EW-1 -: TAGW], cyc - iss);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int tag_n;
  int acc;

  initial begin
    bus.inValid  = 1'b0;
    bus.sub      = 1'b0;
    bus.fpuIn1   = '0;
    bus.fpuIn2   = '0;
    bus.inTag    = '0;
    bus.outReady = 1'b1;

    // Reset values while reset is held.
    #12;
    check("reset_outputs_zero",
          {bus.outValid, bus.outTag, bus.fpuOut, bus.condCodes, bus.opStatusFlags}, 0);
    #10 reset = 1'b0;
    @(negedge clock);
    check("inReady_after_reset", bus.inReady, 1);

    // Directed vectors, back-to-back, outReady held high.
    //    sub  a        b        tag   out      cc       flags
    send(0, 16'h3C00, 16'h4000, 4'd1, 16'h4200, 4'b0000, 4'b0000); // 1+2
    send(1, 16'h3C00, 16'h3C00, 4'd2, 16'h0000, 4'b1000, 4'b0000); // 1-1 -> +0
    send(0, 16'h8000, 16'h8000, 4'd3, 16'h8000, 4'b1010, 4'b0000); // -0 + -0
    send(0, 16'h3C00, 16'h1000, 4'd4, 16'h3C00, 4'b0000, 4'b0001); // tie, even
    send(0, 16'h3C01, 16'h1000, 4'd5, 16'h3C02, 4'b0000, 4'b0001); // tie, round up
    send(0, 16'h7BFF, 16'h7BFF, 4'd6, 16'h7C00, 4'b0001, 4'b0101); // overflow
    send(1, 16'h7C00, 16'h7C00, 4'd7, 16'h7E00, 4'b0000, 4'b1000); // Inf-Inf
    send(0, 16'h0001, 16'h0001, 4'd8, 16'h0002, 4'b0000, 4'b0000); // subnormals
    send(0, 16'h7C00, 16'h3C00, 4'd9, 16'h7C00, 4'b0000, 4'b0000); // Inf+1
    send(1, 16'h3C00, 16'h7C00, 4'd10, 16'hFC00, 4'b0010, 4'b0000); // 1-Inf
    send(0, 16'h7E00, 16'h3C00, 4'd11, 16'h7E00, 4'b0000, 4'b0000); // qNaN in
    send(0, 16'h7D00, 16'h3C00, 4'd12, 16'h7E00, 4'b0000, 4'b1000); // sNaN in
    send(1, 16'h4000, 16'h3C00, 4'd13, 16'h3C00, 4'b0000, 4'b0000); // 2-1
    send(1, 16'h3C00, 16'h4000, 4'd14, 16'hBC00, 4'b0010, 4'b0000); // 1-2
    send(1, 16'h0400, 16'h03FF, 4'd15, 16'h0001, 4'b0000, 4'b0000); // cancel to subnormal
    wait_drain();

    // Backpressure: outReady low, offer tags 1..5 continuously.
    @(posedge clock);
    #1 bus.outReady = 1'b0;
    chk_lat = 1'b0;
    tag_n = 1;
    acc   = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      drive(0, 16'h3C00, 16'h4000, 4'(tag_n));
      if (bus.inReady) begin
        push_exp(4'(tag_n), 16'h4200, 4'b0000, 4'b0000);
        acc++;
        tag_n++;
      end
    end
    check("stall_accepted_count", acc, 3);
    check("stall_inReady_low", bus.inReady, 0);
    check("stall_head_output", {bus.outValid, bus.outTag, bus.fpuOut}, {1'b1, 4'd1, 16'h4200});
    @(negedge clock);
    check("stall_hold_stable", {bus.outValid, bus.outTag, bus.fpuOut}, {1'b1, 4'd1, 16'h4200});
    @(posedge clock);
    #1 bus.outReady = 1'b1;
    for (int c = 0; c < 20 && tag_n <= 5; c++) begin
      @(negedge clock);
      drive(0, 16'h3C00, 16'h4000, 4'(tag_n));
      if (bus.inReady) begin
        push_exp(4'(tag_n), 16'h4200, 4'b0000, 4'b0000);
        acc++;
        tag_n++;
      end
    end
    @(posedge clock);
    #1 bus.inValid = 1'b0;
    check("stall_total_accepted", acc, 5);
    wait_drain();

    // Asynchronous reset with 3 ops in flight.
    @(posedge clock);
    #1 bus.outReady = 1'b0;
    send(0, 16'h3C00, 16'h4000, 4'd1, 16'h4200, 4'b0000, 4'b0000);
    send(0, 16'h3C00, 16'h1000, 4'd2, 16'h3C00, 4'b0000, 4'b0001);
    send(0, 16'h7BFF, 16'h7BFF, 4'd3, 16'h7C00, 4'b0001, 4'b0101);
    check("inflight_outValid", {bus.outValid, bus.outTag, bus.fpuOut}, {1'b1, 4'd1, 16'h4200});
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs_zero",
          {bus.outValid, bus.outTag, bus.fpuOut, bus.condCodes, bus.opStatusFlags}, 0);
    exp_q.delete();
    iss_q.delete();
    #10 reset = 1'b0;
    @(posedge clock);
    #1 bus.outReady = 1'b1;
    chk_lat = 1'b1;
    send(0, 16'h3C00, 16'h4000, 4'd9, 16'h4200, 4'b0000, 4'b0000);
    wait_drain();

    // Idle window: any stray output shows up as unexpected.
    repeat (10) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
